// File: rtl/spi_slave_2.sv
// SPI mode-0 slave exposing NREG 8-bit registers. Each transaction is a
// command byte {rw, addr[6:0]} followed by one data byte.
module spi_slave_2 #(
  parameter int unsigned NREG = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_over
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cs_sync_q, sck_sync_q, mosi_sync_q;
  logic        sck_prev_q;
  logic [1:0]  vld_q;
  logic        armed_q, armed_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        over_q, over_d;
  logic [7:0]  regs_q [NREG];

  logic        cs_s, mosi_s, sck_rise_c, sck_fall_c;
  logic [7:0]  rx_byte_c, rd_data_c;
  logic        new_addr_ok_c, cur_addr_ok_c, wr_en_c;

  assign cs_s       = cs_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign sck_rise_c = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall_c = ~sck_sync_q[1] & sck_prev_q;
  assign rx_byte_c  = {rx_q[6:0], mosi_s};

  assign new_addr_ok_c = {1'b0, rx_byte_c[6:0]} < 8'(NREG);
  assign cur_addr_ok_c = {1'b0, cmd_q[6:0]} < 8'(NREG);
  assign rd_data_c     = new_addr_ok_c ? regs_q[rx_byte_c[AW-1:0]] : 8'h00;

  // Two-flop synchronizers; vld_q marks when cs_s holds a real pin sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      vld_q       <= 2'b00;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sck_prev_q  <= sck_sync_q[1];
      vld_q       <= {vld_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      cmd_q     <= 8'h00;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      cmd_q     <= cmd_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      over_q    <= over_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else if (wr_en_c) begin
      regs_q[cmd_q[AW-1:0]] <= rx_byte_c;
    end
  end

  // Transaction FSM; a start needs cs seen high after reset (armed_q)
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    cmd_d     = cmd_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    over_d    = 1'b0;
    wr_en_c   = 1'b0;
    if (cs_s) begin
      state_d   = IDLE;
      armed_d   = vld_q[1];
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = CMD;
            armed_d = 1'b0;
          end
        end
        CMD: begin
          if (sck_rise_c) begin
            rx_d      = rx_byte_c;
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            if (bit_cnt_q == 3'd7) begin
              cmd_d   = rx_byte_c;
              state_d = DATA;
              tx_d    = rx_byte_c[7] ? 8'h00 : rd_data_c;
              miso_d  = rx_byte_c[7] ? 1'b0 : rd_data_c[7];
            end
          end
        end
        DATA: begin
          if (sck_rise_c) begin
            rx_d      = rx_byte_c;
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            if (bit_cnt_q == 3'd7) begin
              state_d = DONE;
              over_d  = 1'b1;
              tx_d    = 8'h00;
              miso_d  = 1'b0;
              wr_en_c = cmd_q[7] & cur_addr_ok_c;
            end
          end else if (sck_fall_c && !cmd_q[7] && bit_cnt_q != 3'd0) begin
            // First fall after the command byte leaves bit 7 on the line
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign spi_over = over_q;

endmodule

// File: tb/tb_spi_slave_2.sv
// Scenario bench for spi_slave_2: SPI master tasks, a read-data scoreboard
// queue, and monitors counting spi_over pulses and stray miso activity.
module tb_spi_slave_2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_cs = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_over;

  int errors = 0;
  int checks = 0;
  int over_cnt = 0;
  int miso_hi = 0;
  bit miso_watch = 1'b0;
  logic [7:0] exp_q[$];

  spi_slave_2 #(.NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_over(spi_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_over === 1'b1) over_cnt++;
    if (miso_watch && spi_miso !== 1'b0) miso_hi++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      clk_wait(5);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      clk_wait(5);
      spi_sck = 1'b0;
    end
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] data, input int extra,
                     output logic [7:0] rx_cmd, output logic [7:0] rx_data);
    logic [7:0] dummy;
    spi_cs = 1'b0;
    clk_wait(6);
    send_bits(cmd, 8, rx_cmd);
    send_bits(data, 8, rx_data);
    for (int k = 0; k < extra; k++) send_bits(8'hFF, 8, dummy);
    clk_wait(6);
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    clk_wait(8);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input int extra,
                          input string name);
    logic [7:0] rc, rd;
    over_cnt = 0;
    miso_hi = 0;
    miso_watch = 1'b1;
    txn(cmd, data, extra, rc, rd);
    miso_watch = 1'b0;
    checks++;
    if (over_cnt !== 1) begin
      errors++;
      $display("FAIL %s over_pulses: got %0d want 1", name, over_cnt);
    end
    checks++;
    if (miso_hi !== 0) begin
      errors++;
      $display("FAIL %s miso_quiet: got %0d high cycles want 0", name, miso_hi);
    end
  endtask

  task automatic do_read(input logic [6:0] addr, input logic [7:0] expv, input string name);
    logic [7:0] rc, rd, e;
    exp_q.push_back(expv);
    over_cnt = 0;
    txn({1'b0, addr}, 8'h00, 0, rc, rd);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL %s read_data addr=%0d: got %02h want %02h", name, addr, rd, e);
    end
    checks++;
    if (rc !== 8'h00) begin
      errors++;
      $display("FAIL %s cmd_phase_miso: got %02h want 00", name, rc);
    end
    checks++;
    if (over_cnt !== 1) begin
      errors++;
      $display("FAIL %s read_over: got %0d want 1", name, over_cnt);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    spi_cs = 1'b1;
    clk_wait(20);
    checks++;
    if (spi_miso !== 1'b0 || spi_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got miso=%b over=%b want 0 0", spi_miso, spi_over);
    end
    rst_n = 1'b1;
    clk_wait(5);
    for (int a = 0; a < 8; a++) do_read(7'(a), 8'h00, "reset");
  endtask

  task automatic test_write;
    do_write(8'h81, 8'h04, 0, "write");
  endtask

  task automatic test_read;
    do_read(7'd1, 8'h04, "read");
    do_read(7'd1, 8'h04, "read_again");
  endtask

  task automatic test_abort;
    logic [7:0] rc, rd;
    over_cnt = 0;
    spi_cs = 1'b0;
    clk_wait(6);
    send_bits(8'h82, 8, rc);
    send_bits(8'hF0, 4, rd);
    clk_wait(6);
    spi_cs = 1'b1;
    clk_wait(8);
    checks++;
    if (over_cnt !== 0) begin
      errors++;
      $display("FAIL abort_over: got %0d want 0", over_cnt);
    end
    do_read(7'd2, 8'h00, "abort_unchanged");
    do_write(8'h82, 8'h5A, 0, "abort_rewrite");
    do_read(7'd2, 8'h5A, "abort_rewrite");
  endtask

  task automatic test_out_of_range;
    do_write(8'h8F, 8'h55, 0, "oor_write");
    do_read(7'd15, 8'h00, "oor_read");
    do_read(7'd7, 8'h00, "oor_alias");
    do_read(7'd1, 8'h04, "oor_r1");
    do_read(7'd2, 8'h5A, "oor_r2");
  endtask

  task automatic test_extra_bytes;
    do_write(8'h83, 8'hA5, 1, "extra");
    do_read(7'd3, 8'hA5, "extra");
    do_read(7'd7, 8'h00, "extra_r7");
  endtask

  task automatic test_reset_mid;
    logic [7:0] rc, rd;
    over_cnt = 0;
    spi_cs = 1'b0;
    clk_wait(6);
    send_bits(8'h84, 8, rc);
    send_bits(8'hF0, 4, rd);
    rst_n = 1'b0;
    clk_wait(3);
    rst_n = 1'b1;
    send_bits(8'hF0, 4, rd);
    send_bits(8'h85, 8, rd);
    send_bits(8'h33, 8, rd);
    clk_wait(6);
    spi_cs = 1'b1;
    clk_wait(8);
    checks++;
    if (over_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_over: got %0d want 0", over_cnt);
    end
    do_read(7'd4, 8'h00, "reset_mid_r4");
    do_read(7'd5, 8'h00, "reset_mid_r5");
    do_read(7'd1, 8'h00, "reset_mid_r1");
    do_write(8'h86, 8'hC3, 0, "post_reset");
    do_read(7'd6, 8'hC3, "post_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_out_of_range();
    test_extra_bytes();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_2.md
SPI_SLAVE_2 -- requirements
Module: spi_slave_2

Interface
REQ-001 Parameter: NREG, 8, number of 8-bit registers; register addresses 0..NREG-1; NREG is at most 128.
REQ-002 clk  input  1  system clock; SPI sck period is at least 8 clk periods.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 spi_cs  input  1  chip select, active low, asynchronous to clk.
REQ-005 spi_sck  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
REQ-006 spi_mosi  input  1  master-out data, MSB first.
REQ-007 spi_miso  output  1  slave-out data, MSB first, always driven.
REQ-008 spi_over  output  1  one-clk pulse marking completion of a valid transaction.

Function
REQ-009 Synchronize spi_cs, spi_sck and spi_mosi into clk with two flip-flops each; sck edges are detected on the synchronized signal.
REQ-010 Sample spi_mosi on each sck rising edge while cs is low; shift it into the receive register LSB-side, so the byte is MSB first.
REQ-011 A transaction is two bytes: command byte {rw, addr[6:0]}, then data byte.
REQ-012 rw=1 is a write; the data byte is stored to reg[addr] on the 16th rising edge; spi_miso=0 for the whole transaction.
REQ-013 rw=0 is a read; the data byte from mosi is ignored and no register changes.
REQ-014 Read output: on the 8th rising edge, load the transmit shift register with reg[addr] and drive its bit 7 on spi_miso.
REQ-015 Read output: on the sck falling edges following data-byte rising edges 1..7, drive bits 6..0 in order.
REQ-016 In a read, the falling edge after the command byte's 8th rising edge does not shift.
REQ-017 Address at or above NREG: writes are discarded and reads return 0x00; spi_over still pulses.
REQ-018 FSM states and transitions:
- IDLE: leaves to CMD on cs low.
- CMD: leaves to DATA after 8 bits.
- DATA: leaves to DONE after 8 bits.
- DONE: ignores all sck and mosi and holds spi_miso=0.
- Any state: returns to IDLE when synchronized cs is high.
REQ-019 spi_over pulses high for exactly one clk in the same cycle as the DATA to DONE transition, for both read and write.
REQ-020 spi_over timing: it pulses no later than 4 clk after the 16th sck rising edge at the pin.
REQ-021 cs high mid-transaction aborts: bit counters clear, no write, no spi_over, spi_miso=0.
REQ-022 While cs is high, spi_miso=0 and sck/mosi activity is ignored.
REQ-023 A new transaction needs a cs high-then-low sequence; consecutive transactions under one cs low are not supported (bytes after DONE are ignored).
REQ-024 Registers are readable and writable only via SPI; there is no parallel port.

Reset
REQ-025 rst_n low asynchronously clears:
- all registers to 0x00;
- FSM to IDLE;
- bit counters and shift registers to 0;
- synchronizers to cs=1, sck=0, mosi=0;
- spi_miso=0 and spi_over=0.
REQ-026 Reset asserted mid-transaction aborts it with no write and no spi_over; after release, the block waits for cs high then low.

Verification
REQ-027 Reset: rst_n=0 for 20 clk with cs=1 -> spi_miso=0, spi_over=0, all registers read back 0x00.
REQ-028 Write: cs low, send 0x81 then 0x04 (sck half-period 5 clk), cs high -> reg[1]=0x04, one spi_over pulse, spi_miso=0 throughout.
REQ-029 Read: after REQ-028, cs low, send 0x01 then 0x00 -> spi_miso shows 0,0,0,0,0,1,0,0 at data-byte rising edges, one spi_over pulse, reg[1] unchanged.
REQ-030 Abort: cs low, 0x82 sent, then 4 data bits, then cs high -> reg[2] unchanged, no spi_over; the next full write to reg[2] succeeds.
REQ-031 Out-of-range: write 0x8F/0x55, then read 0x0F -> returns 0x00, spi_over pulses both times, other registers unchanged.
REQ-032 Extra bytes: write 0x83/0xA5 followed by 0xFF with cs still low -> reg[3]=0xA5, exactly one spi_over pulse.
